// File: rtl/mod_correct_serial_if.sv
// mod_correct_serial_if: start/operand/result bundle for the serial modular correction stage
//   vld_in  start strobe (master -> slave)
//   din     adder result, N+1 bits (master -> slave)
//   neg     sign of din for post-subtraction correction (master -> slave)
//   mode    1 = post-addition, 0 = post-subtraction (master -> slave)
//   mod_n   modulus n (master -> slave)
//   dout    canonical residue in [0, n-1] (slave -> master)
//   busy    operation in progress (slave -> master)
//   vld_out one-cycle result-valid pulse (slave -> master)
interface mod_correct_serial_if #(
    parameter int N = 4096
);
    logic         vld_in;
    logic [N:0]   din;
    logic         neg;
    logic         mode;
    logic [N-1:0] mod_n;
    logic [N-1:0] dout;
    logic         busy;
    logic         vld_out;
    modport master (output vld_in, din, neg, mode, mod_n, input dout, busy, vld_out);
    modport slave (input vld_in, din, neg, mode, mod_n, output dout, busy, vld_out);
endinterface

// File: rtl/mod_correct_serial.sv
// mod_correct_serial: block-serial conditional subtract/add of n giving the canonical residue
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of mod_correct_serial_if (vld_in/din/neg/mode/mod_n in, dout/busy/vld_out out)
// Operands are rotated right by Block each RUN cycle so the active block always sits at
// bit 0; after max_k rotations din_r is back in its original order for the pass-through
// case, and the partial results have been shifted into t_r from the top.
module mod_correct_serial #(
    parameter int N     = 4096,
    parameter int Block = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mod_correct_serial_if.slave  bus
);
    localparam int max_k = N / Block;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t       state;
    logic [7:0]   k;
    logic         c;
    logic         din_top;
    logic         mode_r;
    logic         neg_r;
    logic [N-1:0] din_r;
    logic [N-1:0] n_r;
    logic [N-1:0] t_r;
    logic [Block-1:0] a;
    logic [Block-1:0] b;
    logic [Block:0]   s;
    // s[Block] is the borrow out (mode=1) or carry out (mode=0) of the current block
    always_comb begin
        a = din_r[Block-1:0];
        b = n_r[Block-1:0];
        s = mode_r ? {1'b0, a} - {1'b0, b} - {{Block{1'b0}}, c}
                   : {1'b0, a} + {1'b0, b} + {{Block{1'b0}}, c};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k        <= '0;
            c        <= 1'b0;
            din_top  <= 1'b0;
            mode_r   <= 1'b0;
            neg_r    <= 1'b0;
            din_r    <= '0;
            n_r      <= '0;
            t_r      <= '0;
            bus.dout <= '0;
            bus.busy <= 1'b0;
            bus.vld_out <= 1'b0;
        end else begin
            bus.vld_out <= 1'b0;
            case (state)
                IDLE: if (bus.vld_in) begin
                    din_r    <= bus.din[N-1:0];
                    din_top  <= bus.din[N];
                    n_r      <= bus.mod_n;
                    mode_r   <= bus.mode;
                    neg_r    <= bus.neg;
                    c        <= 1'b0;
                    k        <= '0;
                    bus.busy <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    din_r <= (din_r >> Block) | (N'(a) << (N - Block));
                    n_r   <= (n_r >> Block) | (N'(b) << (N - Block));
                    t_r   <= (t_r >> Block) | (N'(s[Block-1:0]) << (N - Block));
                    c     <= s[Block];
                    k     <= k + 8'd1;
                    if (k == 8'(max_k - 1)) state <= DONE;
                end
                DONE: begin
                    // mode=1: din >= n when din[N] is set or the full-width subtract did not borrow
                    bus.dout    <= (mode_r ? (din_top | ~c) : neg_r) ? t_r : din_r;
                    bus.vld_out <= 1'b1;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_correct_serial.sv
// tb_mod_correct_serial: randomized and directed checks of mod_correct_serial against a residue model
module tb_mod_correct_serial;
    localparam int N = 256;
    localparam int Block = 128;
    localparam int Lat = N / Block + 1;
    logic clk;
    logic rst_n;
    int errors;
    int checks;
    mod_correct_serial_if #(.N(N)) bus ();
    mod_correct_serial #(.N(N), .Block(Block)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [N-1:0] ref_model(input logic [N:0] d, input logic [N-1:0] m, input logic md, input logic ng);
        logic [N+1:0] x;
        if (md) begin
            x = {1'b0, d};
            return (x >= {2'b0, m}) ? N'(x - {2'b0, m}) : d[N-1:0];
        end
        return ng ? N'(d + {1'b0, m}) : d[N-1:0];
    endfunction
    task automatic start(input logic [N:0] d, input logic [N-1:0] m, input logic md, input logic ng);
        bus.din = d;
        bus.mod_n = m;
        bus.mode = md;
        bus.neg = ng;
        bus.vld_in = 1'b1;
        @(posedge clk);
        #1 bus.vld_in = 1'b0;
    endtask
    task automatic wait_done(output int lat, output logic [N-1:0] res);
        lat = 0;
        res = '0;
        while (lat < 20) begin
            @(posedge clk);
            #1 lat++;
            if (bus.vld_out) begin
                res = bus.dout;
                break;
            end
        end
    endtask
    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.dout !== '0) begin errors++; $display("FAIL reset_dout: got %0h expected 0", bus.dout); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.vld_out !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", bus.vld_out); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    endtask
    task automatic test_add;
        start(257'd1005, 256'd1000, 1'b1, 1'b0);
        checks++; if (bus.busy !== 1'b1 || bus.vld_out !== 1'b0) begin errors++; $display("FAIL add_edge0: got busy=%b vld=%b expected busy=1 vld=0", bus.busy, bus.vld_out); end
        for (int e = 1; e <= Lat + 1; e++) begin
            @(posedge clk);
            #1;
            checks++; if (bus.busy !== (e < Lat)) begin errors++; $display("FAIL add_busy_e%0d: got %b expected %b", e, bus.busy, e < Lat); end
            checks++; if (bus.vld_out !== (e == Lat)) begin errors++; $display("FAIL add_vld_e%0d: got %b expected %b", e, bus.vld_out, e == Lat); end
            if (e == Lat) begin
                checks++; if (bus.dout !== 256'd5) begin errors++; $display("FAIL add_dout: got %0d expected 5", bus.dout); end
            end
        end
    endtask
    task automatic test_boundary;
        int lat;
        logic [N-1:0] r;
        start(257'd999, 256'd1000, 1'b1, 1'b0);
        wait_done(lat, r);
        checks++; if (r !== 256'd999 || lat != Lat) begin errors++; $display("FAIL bnd_n_minus_1: got %0d lat %0d expected 999 lat %0d", r, lat, Lat); end
        start(257'd1000, 256'd1000, 1'b1, 1'b0);
        wait_done(lat, r);
        checks++; if (r !== 256'd0 || lat != Lat) begin errors++; $display("FAIL bnd_eq_n: got %0d lat %0d expected 0 lat %0d", r, lat, Lat); end
    endtask
    task automatic test_cross_block;
        int lat;
        logic [N-1:0] r, m, e;
        logic [N:0] d;
        m = '0; m[128] = 1'b1; m[0] = 1'b1;
        d = '0; d[129] = 1'b1;
        e = '0; e[127:0] = '1;
        start(d, m, 1'b1, 1'b0);
        wait_done(lat, r);
        checks++; if (r !== e) begin errors++; $display("FAIL cross_borrow: got %0h expected %0h", r, e); end
    endtask
    task automatic test_sub;
        int lat;
        logic [N-1:0] r;
        logic [N:0] d;
        d = {(N+1){1'b1}} - 257'd2;
        start(d, 256'd1000, 1'b0, 1'b1);
        wait_done(lat, r);
        checks++; if (r !== 256'd997 || lat != Lat) begin errors++; $display("FAIL sub_neg: got %0d lat %0d expected 997 lat %0d", r, lat, Lat); end
        start(257'd42, 256'd1000, 1'b0, 1'b0);
        wait_done(lat, r);
        checks++; if (r !== 256'd42) begin errors++; $display("FAIL sub_pos: got %0d expected 42", r); end
    endtask
    task automatic test_busy_ignore;
        int nv, at;
        logic [N-1:0] r;
        nv = 0; at = 0; r = '0;
        start(257'd1005, 256'd1000, 1'b1, 1'b0);
        bus.din = 257'd1500;
        bus.vld_in = 1'b1;
        @(posedge clk);
        #1 bus.vld_in = 1'b0;
        for (int e = 2; e <= 9; e++) begin
            @(posedge clk);
            #1;
            if (bus.vld_out) begin nv++; at = e; r = bus.dout; end
        end
        checks++; if (nv != 1) begin errors++; $display("FAIL ignore_count: got %0d pulses expected 1", nv); end
        checks++; if (at != Lat) begin errors++; $display("FAIL ignore_lat: got edge %0d expected %0d", at, Lat); end
        checks++; if (r !== 256'd5) begin errors++; $display("FAIL ignore_dout: got %0d expected 5", r); end
        checks++; if (bus.dout !== 256'd5) begin errors++; $display("FAIL ignore_hold: got %0d expected 5", bus.dout); end
    endtask
    task automatic test_back_to_back;
        int lat;
        logic [N-1:0] r;
        start(257'd1777, 256'd1000, 1'b1, 1'b0);
        wait_done(lat, r);
        checks++; if (r !== 256'd777 || lat != Lat) begin errors++; $display("FAIL b2b_first: got %0d lat %0d expected 777 lat %0d", r, lat, Lat); end
        start(257'd12, 256'd7, 1'b1, 1'b0);
        wait_done(lat, r);
        checks++; if (r !== 256'd5 || lat != Lat) begin errors++; $display("FAIL b2b_second: got %0d lat %0d expected 5 lat %0d", r, lat, Lat); end
    endtask
    task automatic test_reset_mid;
        int nv, lat;
        logic [N-1:0] r;
        nv = 0;
        start(257'd1005, 256'd1000, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.dout !== '0) begin errors++; $display("FAIL rstmid_dout: got %0h expected 0", bus.dout); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #1;
            if (bus.vld_out) nv++;
        end
        checks++; if (nv != 0) begin errors++; $display("FAIL rstmid_vld: got %0d pulses expected 0", nv); end
        start(257'd9, 256'd7, 1'b1, 1'b0);
        wait_done(lat, r);
        checks++; if (r !== 256'd2 || lat != Lat) begin errors++; $display("FAIL rstmid_fresh: got %0d lat %0d expected 2 lat %0d", r, lat, Lat); end
    endtask
    task automatic test_random;
        int lat;
        logic [N-1:0] m, r, e;
        logic [N+1:0] x, two_n, v;
        logic [N:0] d;
        logic md, ng;
        for (int i = 0; i < 60; i++) begin
            for (int w = 0; w < N / 32; w++) m[w*32+:32] = $urandom;
            m = m >> $urandom_range(0, N - 1);
            if (m == '0) m = 256'd1;
            x = '0;
            for (int w = 0; w < (N + 2) / 32 + 1; w++) x = (x << 32) | (N+2)'($urandom);
            two_n = {1'b0, m, 1'b0};
            v = x % two_n;
            md = 1'($urandom);
            if (md) begin
                d = v[N:0];
                ng = 1'b0;
            end else begin
                ng = v < {2'b0, m};
                d = (N+1)'(v - {2'b0, m});
            end
            e = ref_model(d, m, md, ng);
            start(d, m, md, ng);
            wait_done(lat, r);
            checks++; if (r !== e || lat != Lat) begin errors++; $display("FAIL rand_%0d mode=%b: got %0h lat %0d expected %0h lat %0d", i, md, r, lat, e, Lat); end
        end
    endtask
    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        errors = 0;
        checks = 0;
        bus.vld_in = 1'b0;
        bus.din = '0;
        bus.mod_n = '0;
        bus.mode = 1'b0;
        bus.neg = 1'b0;
        test_reset;
        test_add;
        test_boundary;
        test_cross_block;
        test_sub;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mod_correct_serial.md
Name: mod_correct_serial

Overview:
Block-serial modular correction stage placed directly downstream of the block-serial wide adder/subtractor in the L-function/Paillier datapath. It takes the adder's raw result (N+1 bits plus sign) and modulus n and returns the canonical residue in [0, n-1]. After an addition it conditionally subtracts n; after a subtraction it conditionally adds n. It walks Block bits per cycle, LSB first, with a registered carry/borrow chain, so its timing matches the adder.

Parameters:
N, 4096, operand/modulus width in bits; must be a multiple of Block.
Block, 128, bits processed per cycle.
max, N/Block, number of block cycles per operation; must be ≤ 255 (8-bit index).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
vld_in  input  1  single-cycle start strobe; samples din, neg, mode, mod_n.
din  input  N+1  adder result, unsigned (mode=1) or two's complement N+1-bit (mode=0).
neg  input  1  sign of din from the adder; used only when mode=0.
mode  input  1  1 = post-addition correction, 0 = post-subtraction correction.
mod_n  input  N  modulus n; n > 0.
dout  output  N  corrected residue.
busy  output  1  high while an operation is in progress.
vld_out  output  1  one-cycle pulse, dout valid.

Behaviour:
- Reset (async, rst_n=0): state IDLE; index k=0; carry/borrow=0; dout=0; busy=0; vld_out=0; captured operands cleared. Reset mid-operation aborts the job. No vld_out is produced for it.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: on vld_in=1, register din, mod_n, mode, neg. Set carry=0 and k=0. busy<=1. Go to RUN. While vld_in=0, stay in IDLE.
- RUN: one block per cycle, k = 0..max-1.
  - mode=1: t_k = din[k*Block+:Block] - n[k*Block+:Block] - borrow. Store t_k and the new borrow.
  - mode=0: t_k = din[k*Block+:Block] + n[k*Block+:Block] + carry. Store t_k and the new carry.
  - After block max-1: go to DONE.
- DONE:
  - mode=1: ge = din[N] | ~borrow_final. dout <= ge ? t[N-1:0] : din[N-1:0].
  - mode=0: dout <= neg ? t[N-1:0] : din[N-1:0].
  - vld_out<=1 for exactly one cycle. busy<=0. Go to IDLE.
- Latency: with vld_in sampled at edge 0, vld_out is high after edge max+1 and is sampled high at edge max+2. Latency is constant and independent of data and mode.
- Throughput: a new vld_in may be accepted in the cycle vld_out is high (state is IDLE then). So back-to-back jobs run every max+2 cycles.
- vld_in while busy=1 is ignored. It has no effect on the running job and is not queued.
- dout holds its value until the next DONE or reset.
- Input range:
  - mode=1 requires din in [0, 2n-1].
  - mode=0 requires din in [-n, n-1].
  - Results outside these ranges are unspecified but must not hang the FSM.
- Boundaries:
  - din == n (mode=1) gives 0.
  - din == n-1 gives n-1 unchanged.
  - Borrow/carry must propagate across every block boundary, including into the final din[N] evaluation.

Test Plan:
(All cases use N=256, Block=128, max=2, so latency = vld_out high after edge 3.)
1. mode=1, n=1000, din=1005 -> dout=5; vld_out pulses once, in the cycle after edge 3; busy high for cycles 1-3.
2. mode=1, n=1000, din=999 -> dout=999. Then din=1000 -> dout=0.
3. Cross-block borrow: mode=1, n=2^128+1, din=2^129 -> dout=2^128-1.
4. mode=0, neg=1, n=1000, din=2^257-3 (i.e. -3) -> dout=997. Then neg=0, din=42 -> dout=42.
5. Second vld_in pulse at cycle 1 while busy=1 -> ignored; exactly one vld_out, with the first job's result. A vld_in in the vld_out cycle starts a new job whose vld_out follows 3 edges later.
6. Assert rst_n=0 during RUN (k=1) -> dout=0, busy=0, no vld_out. After release, a fresh job (n=7, din=9, mode=1) gives dout=2.
